// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates two requesters (fetch "f_*" and memory-stage "m_*") onto a
//   single downstream memory port. Each requester has a one-entry request
//   slot. A four-state FSM picks a full slot, issues one downstream request
//   pulse, waits for the response and returns it to the owning requester.
//   When both slots are full, grants alternate between them (round-robin).
//   A watchdog raises a sticky flag if a response takes too long.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   f_req_valid/mode/addr/wdata/wstrb  fetch request (mode 0 = read, 1 = write)
//   f_req_ready                      fetch slot empty (registered)
//   f_resp_valid, f_resp_data        one-cycle fetch response pulse and data
//   m_*                              same set for the memory-stage requester
//   d_req_enable                     one-cycle downstream request pulse
//   d_req_mode/addr/wdata/wstrb      downstream request fields, held until response
//   d_resp_enable, d_resp_data       downstream response pulse and read data
//   timeout_err                      sticky watchdog flag
module mem_arbiter #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        f_req_valid,
   input  logic        f_req_mode,
   input  logic [31:0] f_req_addr,
   input  logic [31:0] f_req_wdata,
   input  logic [3:0]  f_req_wstrb,
   output logic        f_req_ready,
   output logic        f_resp_valid,
   output logic [31:0] f_resp_data,
   input  logic        m_req_valid,
   input  logic        m_req_mode,
   input  logic [31:0] m_req_addr,
   input  logic [31:0] m_req_wdata,
   input  logic [3:0]  m_req_wstrb,
   output logic        m_req_ready,
   output logic        m_resp_valid,
   output logic [31:0] m_resp_data,
   output logic        d_req_enable,
   output logic        d_req_mode,
   output logic [31:0] d_req_addr,
   output logic [31:0] d_req_wdata,
   output logic [3:0]  d_req_wstrb,
   input  logic        d_resp_enable,
   input  logic [31:0] d_resp_data,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;

   localparam logic GNT_F = 1'b0;
   localparam logic GNT_M = 1'b1;
   localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

   state_t      state;
   state_t      state_nxt;

   // request slots
   logic        f_full;
   logic        f_mode;
   logic [31:0] f_addr;
   logic [31:0] f_wdata;
   logic [3:0]  f_wstrb;
   logic        m_full;
   logic        m_mode;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;

   // grant doubles as "last granted" for round-robin tie breaking
   logic        grant;
   logic        sel;
   logic        f_hs;
   logic        m_hs;
   logic        start;
   logic        resp_hit;

   logic [15:0] wd_cnt;
   logic [16:0] wd_inc;

   assign f_hs     = f_req_valid & ~f_full;
   assign m_hs     = m_req_valid & ~m_full;
   assign start    = (state == IDLE) & (f_full | m_full);
   assign resp_hit = (state == WAIT_RESP) & d_resp_enable;
   assign wd_inc   = {1'b0, wd_cnt} + 17'd1;

   // Only one full slot wins outright; on a tie the slot not granted last wins.
   always_comb begin
      if (f_full && !m_full)
         sel = GNT_F;
      else if (m_full && !f_full)
         sel = GNT_M;
      else
         sel = (grant == GNT_M) ? GNT_F : GNT_M;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (f_full || m_full) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_RESP;
         WAIT_RESP: if (d_resp_enable) state_nxt = RESPOND;
         RESPOND:   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      d_req_enable = (state == ISSUE);
      f_resp_valid = (state == RESPOND) && (grant == GNT_F);
      m_resp_valid = (state == RESPOND) && (grant == GNT_M);
      f_req_ready  = ~f_full;
      m_req_ready  = ~m_full;
   end

   // Slots, grant, downstream fields, response data and watchdog
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_full      <= 1'b0;
         f_mode      <= 1'b0;
         f_addr      <= '0;
         f_wdata     <= '0;
         f_wstrb     <= '0;
         m_full      <= 1'b0;
         m_mode      <= 1'b0;
         m_addr      <= '0;
         m_wdata     <= '0;
         m_wstrb     <= '0;
         grant       <= GNT_M;
         d_req_mode  <= 1'b0;
         d_req_addr  <= '0;
         d_req_wdata <= '0;
         d_req_wstrb <= '0;
         f_resp_data <= '0;
         m_resp_data <= '0;
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         // A slot is only cleared while granted (hence full), so clear and
         // capture never coincide for the same slot.
         if (resp_hit && grant == GNT_F) begin
            f_full <= 1'b0;
         end else if (f_hs) begin
            f_full  <= 1'b1;
            f_mode  <= f_req_mode;
            f_addr  <= f_req_addr;
            f_wdata <= f_req_wdata;
            f_wstrb <= f_req_wstrb;
         end

         if (resp_hit && grant == GNT_M) begin
            m_full <= 1'b0;
         end else if (m_hs) begin
            m_full  <= 1'b1;
            m_mode  <= m_req_mode;
            m_addr  <= m_req_addr;
            m_wdata <= m_req_wdata;
            m_wstrb <= m_req_wstrb;
         end

         // Downstream fields load only on a grant, so they stay frozen
         // through ISSUE and WAIT_RESP.
         if (start) begin
            grant <= sel;
            if (sel == GNT_F) begin
               d_req_mode  <= f_mode;
               d_req_addr  <= f_addr;
               d_req_wdata <= f_wdata;
               d_req_wstrb <= f_wstrb;
            end else begin
               d_req_mode  <= m_mode;
               d_req_addr  <= m_addr;
               d_req_wdata <= m_wdata;
               d_req_wstrb <= m_wstrb;
            end
         end

         if (resp_hit) begin
            if (grant == GNT_F)
               f_resp_data <= d_resp_data;
            else
               m_resp_data <= d_resp_data;
         end

         // Counter is zeroed on the way into WAIT_RESP, then counts
         // WAIT_RESP cycles; the flag rises on the edge it reaches TIMEOUT.
         if (state == ISSUE) begin
            wd_cnt <= '0;
         end else if (state == WAIT_RESP) begin
            if (wd_cnt != 16'hFFFF)
               wd_cnt <= wd_inc[15:0];
            if (wd_inc >= TIMEOUT_W)
               timeout_err <= 1'b1;
         end
      end
   end

endmodule
